// File: rtl/count_mon_pkg.sv
// Shared types and constants for count_monitor: FSM states, count type, segment patterns.
package count_mon_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef logic [2:0] cnt_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  function automatic cnt_t cnt_dec(cnt_t c);
    return c - 3'd1;
  endfunction

endpackage

// File: rtl/count_monitor_seg7_decode.sv
// Three-bit count to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_decode
  import count_mon_pkg::*;
(
  input  cnt_t       cnt,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (cnt)
      3'd0: seg = SEG_0;
      3'd1: seg = SEG_1;
      3'd2: seg = SEG_2;
      3'd3: seg = SEG_3;
      3'd4: seg = SEG_4;
      3'd5: seg = SEG_5;
      3'd6: seg = SEG_6;
      3'd7: seg = SEG_7;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/count_monitor.sv
// Monitors a 3-bit down-counter: step checking, wrap counting, sticky error, 7-seg view.
// COUNT_MON_SEG_EN enables the seven-segment decoder; otherwise seg is all-off.
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q1,
  input  logic              q2,
  input  logic              q3,
  input  logic              resync,
  output logic [2:0]        cnt_q,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [6:0]        seg
);

  cnt_t   s_cur, s_prev;
  state_t state;
  logic   sync_done;
  logic   bad_q, wrap_q;
  logic   step_ok, wrap_seen;

  assign step_ok   = (s_cur == cnt_dec(s_prev));
  assign wrap_seen = (s_prev == 3'd0) && (s_cur == 3'd7);
  assign cnt_q     = s_cur;

  // Step verdicts are registered one edge before the FSM acts on them, so an
  // illegal sample surfaces on err two edges after it was captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_cur      <= '0;
      s_prev     <= '0;
      state      <= SYNC;
      sync_done  <= 1'b0;
      bad_q      <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      s_cur      <= {q3, q2, q1};
      s_prev     <= s_cur;
      bad_q      <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_pulse <= 1'b0;
      if (resync) begin
        state     <= SYNC;
        sync_done <= 1'b0;
        err       <= 1'b0;
      end else begin
        bad_q  <= (state == TRACK) && !step_ok;
        wrap_q <= (state == TRACK) && step_ok && wrap_seen;
        case (state)
          SYNC: begin
            if (sync_done) state <= TRACK;
            else           sync_done <= 1'b1;
          end
          TRACK: begin
            if (bad_q) begin
              state <= FAULT;
              err   <= 1'b1;
            end else if (wrap_q) begin
              wrap_pulse <= 1'b1;
              if (wrap_cnt != '1) wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end
          end
          FAULT: ;
          default: begin
            state     <= SYNC;
            sync_done <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef COUNT_MON_SEG_EN
  seg7_decode u_seg (
    .cnt (cnt_q),
    .seg (seg)
  );
`else
  assign seg = SEG_OFF;
`endif

endmodule
